// File: rtl/ub_write_arbiter.sv
// ub_write_arbiter
//   Round-robin arbiter that shares the unified buffer's single write port
//   among N_REQ producers. A grant covers a whole burst; data and valid of
//   the grantee are muxed straight onto the buffer port and the buffer's
//   back-pressure is passed straight back to the grantee.
//
// Optional feature macro: UB_ARB_BURST_LIMIT_EN
//   Defined   : a burst also ends on the beat that brings burst_count to
//               MAX_BURST, so the grantee must re-arbitrate to continue.
//   Undefined : bursts end only on req_last; burst_count saturates.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   req_valid/last/data : per-requester stream (data flattened, i*WIDTH)
//   req_ready           : per-requester ready (only the grantee can see 1)
//   ub_wr_valid/data    : unified buffer write port
//   ub_wr_ready         : unified buffer back-pressure
//   grant_id            : current or most recent grantee
//   busy                : high while a grant is active
//   burst_count         : beats accepted in the current burst
//   dbg_state_o         : FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a beat happens on a cycle where the grantee's req_valid and
// ub_wr_ready are both high; valid never waits on ready, and ready reaches
// a requester only while it holds the grant.
module ub_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   ub_wr_valid,
  output logic [WIDTH-1:0]       ub_wr_data,
  input  logic                   ub_wr_ready,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       burst_count,
  output logic                   dbg_state_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [ID_W-1:0]  last_grant_q;
  logic [CNT_W-1:0] burst_count_q;

  logic             active;
  logic             beat;
  logic             burst_end;
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic [CNT_W-1:0] count_inc;

  // Round-robin scan starting just above the last grantee, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_found && req_valid[(int'(last_grant_q) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(last_grant_q) + k) % N_REQ);
      end
    end
  end

  // Reset gates the datapath so no beat can slip through in the reset cycle.
  assign active = (state_q == ST_GRANT) && !reset;
  assign beat   = active && req_valid[grant_id_q] && ub_wr_ready;

  // Counter saturates at all-ones instead of wrapping.
  assign count_inc = (burst_count_q == '1) ? burst_count_q : burst_count_q + 1'b1;

`ifdef UB_ARB_BURST_LIMIT_EN
  assign burst_end = beat && (req_last[grant_id_q] || (count_inc == CNT_W'(MAX_BURST)));
`else
  assign burst_end = beat && req_last[grant_id_q];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= ID_W'(N_REQ - 1);
      burst_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id_q    <= pick_id;
            burst_count_q <= '0;
            state_q       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (beat) begin
            burst_count_q <= count_inc;
          end
          if (burst_end) begin
            last_grant_q <= grant_id_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ub_wr_valid = active && req_valid[grant_id_q];
  assign ub_wr_data  = req_data[int'(grant_id_q)*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (active) begin
      req_ready[grant_id_q] = ub_wr_ready;
    end
  end

  assign grant_id    = grant_id_q;
  assign busy        = (state_q == ST_GRANT);
  assign burst_count = burst_count_q;
  assign dbg_state_o = state_q;

endmodule
